// File: rtl/seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// seq_pattern_tx
//   Serial bit-pattern transmitter that feeds the one-bit input of the Moore
//   sequence detectors. A word of up to DATA_W bits and its length are loaded
//   through a valid/ready handshake and shifted out MSB-first, one bit per
//   clock. The block becomes ready again on the last bit of a word, so
//   back-to-back words form a gapless stream.
//
//   Optional feature macro: SEQ_TX_MATCH_MODEL_EN
//     defined   : a reference model watches the emitted stream and reports
//                 every completion of PATTERN on match / match_count.
//     undefined : match and match_count are tied to zero (ports unchanged).
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   load_valid   in   a word is offered
//   load_ready   out  a word is accepted this cycle (IDLE or last bit)
//   load_data    in   word; the low load_len bits are sent
//   load_len     in   number of bits to send, clamped to DATA_W
//   out          out  serial bit (0 whenever out_valid is 0)
//   out_valid    out  out carries a word bit
//   busy         out  a word is in flight
//   done         out  one-cycle pulse on the last bit (or after a 0-length load)
//   match        out  one-cycle pulse the cycle after PATTERN completes
//   match_count  out  saturating count of matches
// -----------------------------------------------------------------------------
module seq_pattern_tx #(
  parameter int unsigned      DATA_W  = 16,
  parameter int unsigned      LEN_W   = 5,
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic [LEN_W-1:0]  load_len,
  output logic              out,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [CNT_W-1:0]  match_count
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sr_q, sr_d;        // bits still to send, next one at MSB
  logic [LEN_W-1:0]    cnt_q, cnt_d;      // bits remaining, including the one on out
  logic                out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                done_q, done_d;

  logic                last_s;
  logic                ready_s;
  logic                accept_s;
  logic [LEN_W-1:0]    len_s;
  logic [LEN_W:0]      shamt_s;
  logic [DATA_W-1:0]   aligned_s;

  // Handshake decode and next-state computation for the shifter FSM.
  always_comb begin
    last_s   = (state_q == ST_SHIFT) && (cnt_q == LEN_W'(1'b1));
    ready_s  = (state_q == ST_IDLE) || last_s;
    accept_s = load_valid & ready_s;
    len_s    = (load_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : load_len;
    // Left-align the word so its first bit (load_data[L-1]) sits at the MSB.
    shamt_s   = (LEN_W+1)'(DATA_W) - {1'b0, len_s};
    aligned_s = load_data << shamt_s;

    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;

    if (accept_s) begin
      if (len_s == {LEN_W{1'b0}}) begin
        // Zero-length word: acknowledge with a done pulse, emit nothing.
        state_d = ST_IDLE;
        cnt_d   = {LEN_W{1'b0}};
        done_d  = 1'b1;
      end else begin
        state_d     = ST_SHIFT;
        out_d       = aligned_s[DATA_W-1];
        out_valid_d = 1'b1;
        sr_d        = {aligned_s[DATA_W-2:0], 1'b0};
        cnt_d       = len_s;
        done_d      = (len_s == LEN_W'(1'b1));
      end
    end else if (last_s) begin
      state_d = ST_IDLE;
      cnt_d   = {LEN_W{1'b0}};
    end else if (state_q == ST_SHIFT) begin
      out_d       = sr_q[DATA_W-1];
      out_valid_d = 1'b1;
      sr_d        = {sr_q[DATA_W-2:0], 1'b0};
      cnt_d       = cnt_q - LEN_W'(1'b1);
      done_d      = (cnt_q == LEN_W'(2'd2));
    end else begin
      state_d = ST_IDLE;
    end
  end

  // Shifter FSM state and registered serial outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sr_q        <= {DATA_W{1'b0}};
      cnt_q       <= {LEN_W{1'b0}};
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign load_ready = ready_s;
  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q == ST_SHIFT);
  assign done       = done_q;

`ifdef SEQ_TX_MATCH_MODEL_EN
  logic [PAT_W-2:0] hist_q, hist_d;   // previous PAT_W-1 stream bits, newest at LSB
  logic             match_q, match_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PAT_W-1:0] window_s;

  // Pattern window over the emitted stream, idle zeros included.
  always_comb begin
    window_s = {hist_q, out_q};
    hist_d   = window_s[PAT_W-2:0];
    match_d  = (window_s == PATTERN);
    if (match_d && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Reference model registers; the count is cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q  <= {(PAT_W-1){1'b0}};
      match_q <= 1'b0;
      count_q <= {CNT_W{1'b0}};
    end else begin
      hist_q  <= hist_d;
      match_q <= match_d;
      count_q <= count_d;
    end
  end

  assign match       = match_q;
  assign match_count = count_q;
`else
  // PATTERN still shapes the port contract in this build; the AND folds to 0.
  assign match       = 1'b0 & (PATTERN != {PAT_W{1'b0}});
  assign match_count = {CNT_W{1'b0}};
`endif

endmodule
